// File: rtl/k6502_sequencer.sv
// k6502 instruction register, cycle-timing state machine and first-pass decode.
// Drives the 20-bit datapath control vector and owns the bring-up program counter.
module k6502_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h8000
) (
    input  logic        ph0,
    input  logic        reset,
    input  logic [7:0]  d,
    input  logic        rdy,
    output logic [19:0] ctl,
    output logic [15:0] pc,
    output logic        bus_rd,
    output logic        sync,
    output logic [7:0]  ir,
    output logic        illegal
);

    typedef enum logic [1:0] {C1, C2, C3, C4} state_t;

    localparam int AC_SB     = 18;
    localparam int ADD_SB_60 = 16;
    localparam int ADD_SB_7  = 15;
    localparam int DB_ADD    = 11;
    localparam int DL_DB     = 7;
    localparam int SB_AC     = 6;
    localparam int SB_X      = 4;
    localparam int SB_Y      = 3;
    localparam int X_SB      = 2;
    localparam int Y_SB      = 1;
    localparam int Z_ADD     = 0;

    state_t      state_q, state_d;
    logic [7:0]  ir_q, ir_d;
    logic [15:0] pc_q, pc_d;

    logic        is_imm;
    logic [19:0] ctl_raw;
    logic        bus_rd_raw;
    logic        illegal_raw;

    assign is_imm = (ir_q == 8'hA9) || (ir_q == 8'hA2) || (ir_q == 8'hA0);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        if (rdy) begin
            case (state_q)
                C1: begin
                    ir_d    = d;
                    pc_d    = pc_q + 16'd1;
                    state_d = C2;
                end
                C2: begin
                    if (is_imm) begin
                        pc_d    = pc_q + 16'd1;
                        state_d = C3;
                    end else begin
                        state_d = C1;
                    end
                end
                C3:      state_d = C4;
                default: state_d = C1;
            endcase
        end
    end

    always_ff @(posedge ph0 or posedge reset) begin
        if (reset) begin
            state_q <= C1;
            ir_q    <= 8'hEA;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    // Decode depends only on registered state and ir; rdy merely gates the result.
    always_comb begin
        ctl_raw     = 20'd0;
        bus_rd_raw  = 1'b0;
        illegal_raw = 1'b0;
        case (state_q)
            C1: bus_rd_raw = 1'b1;
            C2: begin
                case (ir_q)
                    8'hEA: ;
                    8'hAA: begin ctl_raw[AC_SB] = 1'b1; ctl_raw[SB_X]  = 1'b1; end
                    8'hA8: begin ctl_raw[AC_SB] = 1'b1; ctl_raw[SB_Y]  = 1'b1; end
                    8'h8A: begin ctl_raw[X_SB]  = 1'b1; ctl_raw[SB_AC] = 1'b1; end
                    8'h98: begin ctl_raw[Y_SB]  = 1'b1; ctl_raw[SB_AC] = 1'b1; end
                    8'hA9, 8'hA2, 8'hA0: bus_rd_raw = 1'b1;
                    default: illegal_raw = 1'b1;
                endcase
            end
            C3: begin
                ctl_raw[DL_DB]  = 1'b1;
                ctl_raw[DB_ADD] = 1'b1;
                ctl_raw[Z_ADD]  = 1'b1;
            end
            default: begin
                ctl_raw[ADD_SB_60] = 1'b1;
                ctl_raw[ADD_SB_7]  = 1'b1;
                case (ir_q)
                    8'hA9:   ctl_raw[SB_AC] = 1'b1;
                    8'hA2:   ctl_raw[SB_X]  = 1'b1;
                    8'hA0:   ctl_raw[SB_Y]  = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

    assign ctl     = rdy ? ctl_raw : 20'd0;
    assign bus_rd  = rdy & bus_rd_raw;
    assign sync    = rdy & (state_q == C1);
    assign illegal = illegal_raw;
    assign pc      = pc_q;
    assign ir      = ir_q;

endmodule

// File: tb/tb_k6502_sequencer.sv
// Bench for k6502_sequencer: per-cycle vector table over a small program,
// plus hand sequences for mid-instruction reset and program counter wrap.
module tb_k6502_sequencer;

    logic        ph0 = 1'b0;
    logic        reset = 1'b1;
    logic        rst2 = 1'b1;
    logic        rdy = 1'b1;
    logic [7:0]  d, d2;
    logic [19:0] ctl, ctl2;
    logic [15:0] pc, pc2;
    logic        bus_rd, bus_rd2, sync, sync2, illegal, illegal2;
    logic [7:0]  ir, ir2;

    logic [7:0] mem [0:65535];

    int total = 0;
    int passed = 0;

    always #5 ph0 = ~ph0;

    assign d  = mem[pc];
    assign d2 = mem[pc2];

    k6502_sequencer #(.RESET_PC(16'h8000)) dut (
        .ph0(ph0), .reset(reset), .d(d), .rdy(rdy), .ctl(ctl), .pc(pc),
        .bus_rd(bus_rd), .sync(sync), .ir(ir), .illegal(illegal)
    );

    k6502_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
        .ph0(ph0), .reset(rst2), .d(d2), .rdy(rdy), .ctl(ctl2), .pc(pc2),
        .bus_rd(bus_rd2), .sync(sync2), .ir(ir2), .illegal(illegal2)
    );

    typedef struct {
        logic        rdy;
        logic        sync;
        logic        rd;
        logic [19:0] ctl;
        logic [15:0] pc;
        logic [7:0]  ir;
        logic        ill;
    } vec_t;

    vec_t vt [0:28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step;
        @(posedge ph0);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        // A9 42, AA, A8, 8A, 98, FF, A2 55, EA, A0 77, A9 11
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        mem[16'h8002] = 8'hAA; mem[16'h8003] = 8'hA8;
        mem[16'h8004] = 8'h8A; mem[16'h8005] = 8'h98;
        mem[16'h8006] = 8'hFF; mem[16'h8007] = 8'hA2;
        mem[16'h8008] = 8'h55; mem[16'h8009] = 8'hEA;
        mem[16'h800A] = 8'hA0; mem[16'h800B] = 8'h77;
        mem[16'h800C] = 8'hA9; mem[16'h800D] = 8'h11;
        mem[16'hFFFF] = 8'hA0; mem[16'h0000] = 8'h5A;
        mem[16'h0001] = 8'hEA;

        //            rdy sync rd  ctl        pc        ir     ill
        vt[0]  = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8000, 8'hEA, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 20'h00000, 16'h8001, 8'hA9, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 20'h00881, 16'h8002, 8'hA9, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 20'h18040, 16'h8002, 8'hA9, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8002, 8'hA9, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 20'h40010, 16'h8003, 8'hAA, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8003, 8'hAA, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 20'h40008, 16'h8004, 8'hA8, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8004, 8'hA8, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 20'h00044, 16'h8005, 8'h8A, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8005, 8'h8A, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 20'h00042, 16'h8006, 8'h98, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8006, 8'h98, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 20'h00000, 16'h8007, 8'hFF, 1'b1};
        vt[14] = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8007, 8'hFF, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b1, 20'h00000, 16'h8008, 8'hA2, 1'b0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 20'h00000, 16'h8009, 8'hA2, 1'b0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 20'h00000, 16'h8009, 8'hA2, 1'b0};
        vt[18] = '{1'b0, 1'b0, 1'b0, 20'h00000, 16'h8009, 8'hA2, 1'b0};
        vt[19] = '{1'b1, 1'b0, 1'b0, 20'h00881, 16'h8009, 8'hA2, 1'b0};
        vt[20] = '{1'b1, 1'b0, 1'b0, 20'h18010, 16'h8009, 8'hA2, 1'b0};
        vt[21] = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h8009, 8'hA2, 1'b0};
        vt[22] = '{1'b1, 1'b0, 1'b0, 20'h00000, 16'h800A, 8'hEA, 1'b0};
        vt[23] = '{1'b0, 1'b0, 1'b0, 20'h00000, 16'h800A, 8'hEA, 1'b0};
        vt[24] = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h800A, 8'hEA, 1'b0};
        vt[25] = '{1'b1, 1'b0, 1'b1, 20'h00000, 16'h800B, 8'hA0, 1'b0};
        vt[26] = '{1'b1, 1'b0, 1'b0, 20'h00881, 16'h800C, 8'hA0, 1'b0};
        vt[27] = '{1'b1, 1'b0, 1'b0, 20'h18008, 16'h800C, 8'hA0, 1'b0};
        vt[28] = '{1'b1, 1'b1, 1'b1, 20'h00000, 16'h800C, 8'hA0, 1'b0};

        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            rdy = vt[i].rdy;
            @(negedge ph0);
            chk($sformatf("v%0d sync", i),    {31'd0, sync},    {31'd0, vt[i].sync});
            chk($sformatf("v%0d bus_rd", i),  {31'd0, bus_rd},  {31'd0, vt[i].rd});
            chk($sformatf("v%0d ctl", i),     {12'd0, ctl},     {12'd0, vt[i].ctl});
            chk($sformatf("v%0d pc", i),      {16'd0, pc},      {16'd0, vt[i].pc});
            chk($sformatf("v%0d ir", i),      {24'd0, ir},      {24'd0, vt[i].ir});
            chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vt[i].ill});
            step();
        end
        rdy = 1'b1;

        // Now in C2 of A9 at 800C; advance into C3 and reset mid-cycle.
        @(negedge ph0);
        chk("mid C2 bus_rd", {31'd0, bus_rd}, 32'd1);
        step();
        @(negedge ph0);
        chk("mid C3 ctl", {12'd0, ctl}, 32'h00881);
        #1 reset = 1'b1;
        #1;
        chk("rst async ctl",     {12'd0, ctl},     32'h0);
        chk("rst async sync",    {31'd0, sync},    32'd1);
        chk("rst async bus_rd",  {31'd0, bus_rd},  32'd1);
        chk("rst async pc",      {16'd0, pc},      32'h8000);
        chk("rst async ir",      {24'd0, ir},      32'hEA);
        chk("rst async illegal", {31'd0, illegal}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge ph0);
        chk("post-rst pc",   {16'd0, pc},   32'h8000);
        chk("post-rst sync", {31'd0, sync}, 32'd1);
        step();
        @(negedge ph0);
        chk("refetch ir",     {24'd0, ir},     32'hA9);
        chk("refetch pc",     {16'd0, pc},     32'h8001);
        chk("refetch bus_rd", {31'd0, bus_rd}, 32'd1);

        // Program counter wrap on the second instance.
        step();
        rst2 = 1'b0;
        @(negedge ph0);
        chk("wrap C1 pc",   {16'd0, pc2},   32'hFFFF);
        chk("wrap C1 sync", {31'd0, sync2}, 32'd1);
        step();
        @(negedge ph0);
        chk("wrap C2 pc",     {16'd0, pc2},     32'h0000);
        chk("wrap C2 bus_rd", {31'd0, bus_rd2}, 32'd1);
        chk("wrap C2 ir",     {24'd0, ir2},     32'hA0);
        step();
        @(negedge ph0);
        chk("wrap C3 ctl", {12'd0, ctl2}, 32'h00881);
        chk("wrap C3 pc",  {16'd0, pc2},  32'h0001);
        step();
        @(negedge ph0);
        chk("wrap C4 ctl", {12'd0, ctl2}, 32'h18008);
        step();
        @(negedge ph0);
        chk("wrap next sync", {31'd0, sync2}, 32'd1);
        chk("wrap next pc",   {16'd0, pc2},   32'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
